// File: rtl/fb_arbiter_if.sv
// Frame-buffer arbiter bus: display scan-out port, posted writer, random reader
// and the single-port block RAM, bundled for the arbiter and its environment.
interface fb_arbiter_if #(
    parameter int AW = 19,
    parameter int DW = 16
);
    logic          disp_en;
    logic [AW-1:0] disp_addr;
    logic [DW-1:0] disp_data;
    logic          disp_valid;

    logic          wr_valid;
    logic          wr_ready;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;

    logic          rd_valid;
    logic          rd_ready;
    logic [AW-1:0] rd_addr;
    logic          rd_rvalid;
    logic [DW-1:0] rd_rdata;

    logic          ram_en;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;

    modport slave (
        input  disp_en, disp_addr, wr_valid, wr_addr, wr_data, rd_valid, rd_addr, ram_rdata,
        output disp_data, disp_valid, wr_ready, rd_ready, rd_rvalid, rd_rdata,
               ram_en, ram_we, ram_addr, ram_wdata
    );

    modport master (
        output disp_en, disp_addr, wr_valid, wr_addr, wr_data, rd_valid, rd_addr, ram_rdata,
        input  disp_data, disp_valid, wr_ready, rd_ready, rd_rvalid, rd_rdata,
               ram_en, ram_we, ram_addr, ram_wdata
    );
endinterface

// File: rtl/fb_arbiter.sv
// Single-port frame-buffer arbiter: display reads always win, posted writes and
// random reads share leftover cycles round-robin with read-after-write protection.
module fb_arbiter #(
    parameter int AW     = 19,
    parameter int DW     = 16,
    parameter int WDEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    fb_arbiter_if.slave               bus,
    output logic [$clog2(WDEPTH):0]   wfifo_count
);
    localparam int PW = $clog2(WDEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {GNT_NONE, GNT_DISP, GNT_WR, GNT_RD} gnt_e;
    typedef enum logic {LAST_WR, LAST_RD} last_e;
    typedef enum logic [1:0] {TAG_NONE, TAG_DISP, TAG_RD} tag_e;

    logic [AW-1:0] fifo_addr [WDEPTH];
    logic [DW-1:0] fifo_data [WDEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count;
    logic [PW-1:0] offs;
    last_e         last_gnt;
    tag_e          rtag;
    gnt_e          gnt;
    logic          push;
    logic          pop;
    logic          hazard;
    logic          w_cand;
    logic          r_cand;

    assign bus.wr_ready = (count != CW'(WDEPTH)) && !rst;
    assign push         = bus.wr_valid && bus.wr_ready;
    assign pop          = (gnt == GNT_WR);
    assign wfifo_count  = count;

    // An entry is occupied when its distance from head is below the count.
    always_comb begin
        hazard = 1'b0;
        offs   = '0;
        for (int i = 0; i < WDEPTH; i++) begin
            offs = PW'(i) - head;
            if (({1'b0, offs} < count) && (fifo_addr[i] == bus.rd_addr)) begin
                hazard = 1'b1;
            end
        end
    end

    always_comb begin
        w_cand = (count != '0);
        r_cand = bus.rd_valid && !hazard;
        gnt    = GNT_NONE;
        if (rst) begin
            gnt = GNT_NONE;
        end else if (bus.disp_en) begin
            gnt = GNT_DISP;
        end else if (w_cand && r_cand) begin
            gnt = (last_gnt == LAST_RD) ? GNT_WR : GNT_RD;
        end else if (w_cand) begin
            gnt = GNT_WR;
        end else if (r_cand) begin
            gnt = GNT_RD;
        end
    end

    always_comb begin
        bus.ram_en   = 1'b0;
        bus.ram_we   = 1'b0;
        bus.ram_addr = bus.disp_addr;
        bus.rd_ready = 1'b0;
        case (gnt)
            GNT_DISP: bus.ram_en = 1'b1;
            GNT_WR: begin
                bus.ram_en   = 1'b1;
                bus.ram_we   = 1'b1;
                bus.ram_addr = fifo_addr[head];
            end
            GNT_RD: begin
                bus.ram_en   = 1'b1;
                bus.ram_addr = bus.rd_addr;
                bus.rd_ready = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.ram_wdata  = fifo_data[head];
    assign bus.disp_valid = (rtag == TAG_DISP) && !rst;
    assign bus.rd_rvalid  = (rtag == TAG_RD) && !rst;
    assign bus.disp_data  = bus.ram_rdata;
    assign bus.rd_rdata   = bus.ram_rdata;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[tail] <= bus.wr_addr;
            fifo_data[tail] <= bus.wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            last_gnt <= LAST_RD;
            rtag     <= TAG_NONE;
        end else begin
            if (push) tail <= tail + 1'b1;
            if (pop)  head <= head + 1'b1;
            count <= count + CW'(push) - CW'(pop);
            if (gnt == GNT_WR) begin
                last_gnt <= LAST_WR;
            end else if (gnt == GNT_RD) begin
                last_gnt <= LAST_RD;
            end
            case (gnt)
                GNT_DISP: rtag <= TAG_DISP;
                GNT_RD:   rtag <= TAG_RD;
                default:  rtag <= TAG_NONE;
            endcase
        end
    end
endmodule

// File: tb/tb_fb_arbiter.sv
// Bench for fb_arbiter: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a queue-based arbiter model.
`timescale 1ns/1ps
module tb_fb_arbiter;
    localparam int AW     = 19;
    localparam int DW     = 16;
    localparam int WDEPTH = 4;
    localparam int CW     = $clog2(WDEPTH) + 1;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wentry_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [CW-1:0] wfifo_count;

    fb_arbiter_if #(.AW(AW), .DW(DW)) ifc ();

    fb_arbiter #(.AW(AW), .DW(DW), .WDEPTH(WDEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (ifc),
        .wfifo_count (wfifo_count)
    );

    always #5 clk = ~clk;

    int checks_total  = 0;
    int checks_passed = 0;

    // Model state: posted writes in arrival order, who won the last W/R tie,
    // and what the read issued last cycle must return.
    wentry_t       wq[$];
    bit            model_on  = 1'b0;
    bit            last_w    = 1'b0;
    int            pend_kind = 0;
    logic [DW-1:0] pend_data = '0;
    logic [DW-1:0] model_mem [logic [AW-1:0]];
    logic [DW-1:0] env_mem   [logic [AW-1:0]];

    function automatic logic [DW-1:0] init_word(input logic [AW-1:0] a);
        if (a == 19'h00010) return 16'h0F0F;
        return a[DW-1:0] ^ 16'hA5A5;
    endfunction

    function automatic logic [DW-1:0] mem_read(input logic [AW-1:0] a);
        if (model_mem.exists(a)) return model_mem[a];
        return init_word(a);
    endfunction

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks_total++;
        if (actual !== expected)
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        else
            checks_passed++;
    endtask

    task automatic model_cycle();
        int            g;
        bit            haz;
        bit            wc;
        bit            rc;
        bit            wr_ok;
        wentry_t       e;
        g     = 0;
        haz   = 1'b0;
        foreach (wq[i]) if (wq[i].addr == ifc.rd_addr) haz = 1'b1;
        wc    = (wq.size() != 0);
        rc    = (ifc.rd_valid === 1'b1) && !haz;
        wr_ok = (wq.size() < WDEPTH);
        if (rst)                g = 0;
        else if (ifc.disp_en)   g = 1;
        else if (wc && rc)      g = last_w ? 3 : 2;
        else if (wc)            g = 2;
        else if (rc)            g = 3;

        if (model_on) begin
            check_output("wr_ready", ifc.wr_ready, !rst && wr_ok);
            check_output("wfifo_count", wfifo_count, wq.size());
            check_output("ram_en", ifc.ram_en, g != 0);
            check_output("ram_we", ifc.ram_we, g == 2);
            check_output("rd_ready", ifc.rd_ready, g == 3);
            if (g == 1) check_output("ram_addr_disp", ifc.ram_addr, ifc.disp_addr);
            if (g == 3) check_output("ram_addr_rd", ifc.ram_addr, ifc.rd_addr);
            if (g == 2) begin
                check_output("ram_addr_wr", ifc.ram_addr, wq[0].addr);
                check_output("ram_wdata", ifc.ram_wdata, wq[0].data);
            end
            check_output("disp_valid", ifc.disp_valid, !rst && pend_kind == 1);
            check_output("rd_rvalid", ifc.rd_rvalid, !rst && pend_kind == 2);
            if (!rst && pend_kind == 1) check_output("disp_data", ifc.disp_data, pend_data);
            if (!rst && pend_kind == 2) check_output("rd_rdata", ifc.rd_rdata, pend_data);
        end

        if (rst) begin
            wq.delete();
            last_w    = 1'b0;
            pend_kind = 0;
            model_on  = 1'b1;
        end else if (model_on) begin
            if (g == 2) begin
                e = wq.pop_front();
                model_mem[e.addr] = e.data;
                last_w = 1'b1;
            end
            if (g == 3) last_w = 1'b0;
            pend_kind = (g == 1) ? 1 : (g == 3) ? 2 : 0;
            pend_data = (g == 1) ? mem_read(ifc.disp_addr) : mem_read(ifc.rd_addr);
            if (ifc.wr_valid && wr_ok) begin
                e.addr = ifc.wr_addr;
                e.data = ifc.wr_data;
                wq.push_back(e);
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            model_cycle();
        end
    end

    // Synchronous RAM stand-in: request seen mid-cycle, read data appears after the edge.
    initial begin
        logic [AW-1:0] ra;
        logic          rd_pend;
        ra = '0;
        ifc.ram_rdata = '0;
        forever begin
            @(negedge clk);
            rd_pend = 1'b0;
            if (ifc.ram_en === 1'b1) begin
                if (ifc.ram_we === 1'b1) begin
                    env_mem[ifc.ram_addr] = ifc.ram_wdata;
                end else begin
                    rd_pend = 1'b1;
                    ra      = ifc.ram_addr;
                end
            end
            @(posedge clk);
            if (rd_pend) ifc.ram_rdata = env_mem.exists(ra) ? env_mem[ra] : init_word(ra);
        end
    end

    task automatic apply_stimulus(input logic r, input logic de, input logic [AW-1:0] da,
                                  input logic wv, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                                  input logic rv, input logic [AW-1:0] ra);
        @(posedge clk);
        #1;
        rst           = r;
        ifc.disp_en   = de;
        ifc.disp_addr = da;
        ifc.wr_valid  = wv;
        ifc.wr_addr   = wa;
        ifc.wr_data   = wd;
        ifc.rd_valid  = rv;
        ifc.rd_addr   = ra;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) apply_stimulus(1'b0, 1'b0, '0, 1'b0, '0, '0, 1'b0, '0);
    endtask

    task automatic reset_dut();
        repeat (2) apply_stimulus(1'b1, 1'b0, '0, 1'b0, '0, '0, 1'b0, '0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [5:0] seq;
        int         reads;
        int         gnt_cycle;
        bit         wseen;

        rst = 1'b1;
        ifc.disp_en = 1'b1; ifc.disp_addr = '0;
        ifc.wr_valid = 1'b1; ifc.wr_addr = '0; ifc.wr_data = '0;
        ifc.rd_valid = 1'b1; ifc.rd_addr = '0;

        // Reset held with every requester active.
        repeat (3) apply_stimulus(1'b1, 1'b1, '0, 1'b1, '0, '0, 1'b1, '0);
        check_output("rst_count", wfifo_count, 0);
        check_output("rst_ram_en", ifc.ram_en, 0);
        check_output("rst_wr_ready", ifc.wr_ready, 0);
        check_output("rst_rd_ready", ifc.rd_ready, 0);
        check_output("rst_disp_valid", ifc.disp_valid, 0);
        check_output("rst_rd_rvalid", ifc.rd_rvalid, 0);
        idle(1);
        check_output("release_wr_ready", ifc.wr_ready, 1);

        // Display priority over a pending reader and a non-empty FIFO.
        apply_stimulus(1'b0, 1'b1, 19'h00020, 1'b1, 19'h00200, 16'hAAAA, 1'b0, '0);
        apply_stimulus(1'b0, 1'b1, 19'h00021, 1'b1, 19'h00201, 16'hBBBB, 1'b0, '0);
        apply_stimulus(1'b0, 1'b1, 19'h00010, 1'b0, '0, '0, 1'b1, 19'h00500);
        check_output("disp_ram_addr", ifc.ram_addr, 32'h10);
        check_output("disp_ram_we", ifc.ram_we, 0);
        check_output("disp_rd_ready", ifc.rd_ready, 0);
        check_output("disp_fifo_count", wfifo_count, 2);
        idle(1);
        check_output("disp_valid_next", ifc.disp_valid, 1);
        check_output("disp_data_next", ifc.disp_data, 32'h0F0F);
        idle(4);

        // Round-robin between four posted writes and a two-request reader.
        reset_dut();
        for (int k = 0; k < 4; k++)
            apply_stimulus(1'b0, 1'b1, 19'h00030, 1'b1, AW'(32'h300 + k), DW'(32'hC000 + k), 1'b0, '0);
        seq = '0;
        reads = 0;
        for (int k = 0; k < 6; k++) begin
            apply_stimulus(1'b0, 1'b0, '0, 1'b0, '0, '0, reads < 2, 19'h00400);
            seq = {seq[4:0], ifc.ram_en & ifc.ram_we};
            if (ifc.rd_ready) reads++;
        end
        check_output("rr_grant_order", seq, 6'b101011);
        check_output("rr_reads", reads, 2);
        idle(2);

        // Read-after-write hazard: the read waits until its address drains.
        reset_dut();
        apply_stimulus(1'b0, 1'b1, 19'h00030, 1'b1, 19'h00201, 16'h1111, 1'b0, '0);
        apply_stimulus(1'b0, 1'b1, 19'h00030, 1'b1, 19'h00202, 16'h2222, 1'b0, '0);
        apply_stimulus(1'b0, 1'b1, 19'h00030, 1'b1, 19'h00100, 16'h1234, 1'b0, '0);
        wseen = 1'b0;
        gnt_cycle = -1;
        for (int k = 0; k < 10 && gnt_cycle < 0; k++) begin
            apply_stimulus(1'b0, 1'b0, '0, 1'b0, '0, '0, 1'b1, 19'h00100);
            if (ifc.rd_ready) begin
                gnt_cycle = k;
                check_output("raw_write_first", wseen, 1);
            end
            if (ifc.ram_en && ifc.ram_we && ifc.ram_addr == 19'h00100) wseen = 1'b1;
        end
        check_output("raw_grant_cycle", gnt_cycle, 3);
        idle(1);
        check_output("raw_rvalid", ifc.rd_rvalid, 1);
        check_output("raw_rdata", ifc.rd_rdata, 32'h1234);
        idle(1);

        // FIFO fill while the display blocks draining, then in-order drain.
        reset_dut();
        for (int k = 0; k < 6; k++) begin
            apply_stimulus(1'b0, 1'b1, 19'h00030, 1'b1, AW'(32'h600 + k), DW'(32'hB000 + k), 1'b0, '0);
            check_output("full_count", wfifo_count, (k < 4) ? k : 4);
            check_output("full_wr_ready", ifc.wr_ready, k < 4);
        end
        for (int k = 0; k < 4; k++) begin
            apply_stimulus(1'b0, 1'b0, '0, 1'b0, '0, '0, 1'b0, '0);
            check_output("drain_we", ifc.ram_we, 1);
            check_output("drain_addr", ifc.ram_addr, 32'h600 + k);
            check_output("drain_wdata", ifc.ram_wdata, 32'hB000 + k);
            check_output("drain_count", wfifo_count, 4 - k);
            check_output("drain_wr_ready", ifc.wr_ready, k != 0);
        end
        idle(1);

        // Reset arriving right after a read grant.
        reset_dut();
        for (int k = 0; k < 3; k++)
            apply_stimulus(1'b0, 1'b1, 19'h00030, 1'b1, AW'(32'h650 + k), DW'(32'hD000 + k), 1'b0, '0);
        apply_stimulus(1'b0, 1'b0, '0, 1'b0, '0, '0, 1'b1, 19'h00700);
        check_output("mid_first_w", ifc.ram_we, 1);
        apply_stimulus(1'b0, 1'b0, '0, 1'b0, '0, '0, 1'b1, 19'h00700);
        check_output("mid_rd_grant", ifc.rd_ready, 1);
        apply_stimulus(1'b1, 1'b0, '0, 1'b0, '0, '0, 1'b0, '0);
        check_output("mid_rvalid_suppressed", ifc.rd_rvalid, 0);
        apply_stimulus(1'b1, 1'b0, '0, 1'b0, '0, '0, 1'b0, '0);
        idle(1);
        check_output("mid_fifo_empty", wfifo_count, 0);
        check_output("mid_ram_idle", ifc.ram_en, 0);

        // Random traffic over a small address pool so hazards are frequent.
        for (int k = 0; k < 2000; k++) begin
            apply_stimulus($urandom_range(0, 99) == 0,
                           $urandom_range(0, 99) < 30, AW'(32'h800 + $urandom_range(0, 7)),
                           $urandom_range(0, 1) == 1, AW'(32'h800 + $urandom_range(0, 7)), DW'($urandom),
                           $urandom_range(0, 1) == 1, AW'(32'h800 + $urandom_range(0, 7)));
        end
        idle(2);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end
endmodule
